input_x_sequencer: RTL and testbench
====================================

Name: input_x_sequencer

Overview:
Reads the per-timestep input feature vectors from the input-feature ROM (addr/data, combinational read) and streams them element by element to the LSTM forward datapath over a valid/ready handshake. After the NUM-1 features of each timestep it inserts the constant bias element. It marks the end of each vector and the end of the whole sequence. It sits directly downstream of the feature ROM and upstream of the gate MAC units.

Parameters:
WIDTH, 32, data and address width
NUM, 69, elements per vector: NUM-1 features from ROM plus 1 bias element
NUM_ITERATIONS, 8, timesteps per sequence
BIAS, 32'h0100_0000, value emitted as the bias element (fixed-point 1.0)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  single-cycle request to stream one full sequence
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse after the final element is accepted
mem_addr  output  WIDTH  address to feature ROM, registered
mem_data  input  WIDTH  signed ROM read data, valid in the same cycle as mem_addr
x_out  output  WIDTH  signed element being offered downstream
x_valid  output  1  x_out holds a valid element
x_ready  input  1  downstream accepts x_out when x_valid && x_ready
x_last  output  1  x_out is the bias element, i.e. the last element of the current vector
x_tlast  output  1  x_out is the final bias element of the final timestep
x_step  output  WIDTH  timestep index (0..NUM_ITERATIONS-1) of x_out

Behaviour:
- Reset (any state, including mid-sequence): state IDLE. busy=0, done=0, x_valid=0, x_last=0, x_tlast=0, x_out=0, x_step=0, mem_addr=0. Internal counters f=0, t=0, issued=0. Any partially streamed sequence is abandoned.
- States: IDLE, RUN, DONE.
- IDLE: when start=1, go to RUN, with mem_addr=0, f=0, t=0. start is ignored in RUN and DONE.
- RUN, load condition: a new element is loaded when issued=0 and the output slot is free (x_valid=0, or x_valid && x_ready in the same cycle).
- RUN, load actions:
  - x_out gets mem_data when f<NUM-1, else BIAS.
  - x_last gets (f==NUM-1).
  - x_tlast gets (f==NUM-1 && t==NUM_ITERATIONS-1).
  - x_step gets t.
  - x_valid gets 1.
- RUN, counter update on a load:
  - mem_addr increments only when a ROM element is loaded (f<NUM-1). It is a running counter with no multiplier; address = t*(NUM-1)+f.
  - f wraps NUM-1 to 0, and t increments on the wrap.
  - Loading the final bias sets issued=1.
- Handshake with nothing to load: if x_valid && x_ready and no new element is loaded, x_valid drops to 0. x_out and its flags hold steady while x_valid && !x_ready; there is no ROM read while stalled.
- Leaving RUN: when issued=1 and the final element (x_tlast) is handshaked, go to DONE with x_valid=0.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. A start during the done cycle is ignored.
- Latency and throughput: start sampled at edge n gives RUN at n. The first x_valid=1 with x_out=ROM[0] follows at edge n+1. With x_ready held high, throughput is one element per cycle. A sequence is exactly NUM*NUM_ITERATIONS beats, and done is asserted 1 cycle after the last handshake.
- Address range: mem_addr never exceeds (NUM-1)*NUM_ITERATIONS-1 when presented with a load. After the last feature it may point one past the end, but it is not read.
- Arithmetic: none on data; values pass through unchanged. x_step and the counters are unsigned.

Test Plan:
- NUM=4, NUM_ITERATIONS=2, ROM = 0x11,0x12,0x13,0x21,0x22,0x23; one start pulse, x_ready=1:
  - x_out sequence is 0x11,0x12,0x13,BIAS,0x21,0x22,0x23,BIAS over 8 consecutive cycles.
  - x_last is high on beats 4 and 8; x_tlast only on beat 8; x_step is 0,0,0,0,1,1,1,1.
  - done pulses once, 1 cycle after beat 8.
- Same setup, x_ready toggling 1,0,0,1,... with random stalls: every element is delivered exactly once and in order, x_out is stable while stalled, and there are still 8 beats total.
- Start asserted again mid-sequence and during the done cycle: ignored; a single 8-beat stream.
- rst asserted after beat 3: next cycle x_valid=0, busy=0, mem_addr=0. A new start restarts from 0x11.
- Back-to-back sequences: start 1 cycle after done gives a second identical 8-beat stream, with mem_addr again starting at 0.
- Default parameters (NUM=69, 8 iterations) with ready=1: 552 beats. mem_addr covers 0..543 contiguously, x_last on every 69th beat, done after beat 552.

Source files
------------

// File: rtl/input_x_sequencer.sv
// -----------------------------------------------------------------------------
// input_x_sequencer
//
// Streams per-timestep input feature vectors from the feature ROM into the LSTM
// forward datapath. Each vector has NUM elements: NUM-1 features read from the
// ROM, then one constant BIAS element. A sequence is NUM_ITERATIONS vectors.
// Elements are offered over a valid/ready handshake. The last element of each
// vector is flagged with x_last, and the last element of the sequence is also
// flagged with x_tlast.
//
// Ports
//   clk       : clock; all state changes on the rising edge
//   rst       : synchronous active-high reset; abandons any sequence in flight
//   start     : one-cycle request to stream a full sequence (honoured only in IDLE)
//   busy      : high from the cycle after an accepted start until done
//   done      : one-cycle pulse, one cycle after the final element is accepted
//   mem_addr  : registered feature-ROM address
//   mem_data  : ROM read data, valid in the same cycle as mem_addr
//   x_out     : element offered downstream
//   x_valid   : x_out holds a valid element
//   x_ready   : downstream accepts x_out when x_valid && x_ready
//   x_last    : x_out is the bias element that ends the current vector
//   x_tlast   : x_out is the bias element of the final timestep
//   x_step    : timestep index of x_out
// -----------------------------------------------------------------------------
module input_x_sequencer #(
    parameter int               WIDTH          = 32,
    parameter int               NUM            = 69,
    parameter int               NUM_ITERATIONS = 8,
    parameter logic [WIDTH-1:0] BIAS           = WIDTH'(32'h0100_0000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_data,
    output logic [WIDTH-1:0] x_out,
    output logic             x_valid,
    input  logic             x_ready,
    output logic             x_last,
    output logic             x_tlast,
    output logic [WIDTH-1:0] x_step
);

    localparam logic [WIDTH-1:0] ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] LAST_F = WIDTH'(NUM - 1);
    localparam logic [WIDTH-1:0] LAST_T = WIDTH'(NUM_ITERATIONS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r,    state_s;
    logic             busy_r,     busy_s;
    logic             done_r,     done_s;
    logic [WIDTH-1:0] mem_addr_r, mem_addr_s;
    logic [WIDTH-1:0] x_out_r,    x_out_s;
    logic             x_valid_r,  x_valid_s;
    logic             x_last_r,   x_last_s;
    logic             x_tlast_r,  x_tlast_s;
    logic [WIDTH-1:0] x_step_r,   x_step_s;
    logic [WIDTH-1:0] f_r,        f_s;        // element index within the vector
    logic [WIDTH-1:0] t_r,        t_s;        // timestep index
    logic             issued_r,   issued_s;   // final bias has been loaded
    logic             is_feat_s;              // current element comes from the ROM
    logic             load_s;                 // load a new element this cycle

    // Next-state and next-output logic for the sequencing FSM.
    always_comb begin
        state_s    = state_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        mem_addr_s = mem_addr_r;
        x_out_s    = x_out_r;
        x_valid_s  = x_valid_r;
        x_last_s   = x_last_r;
        x_tlast_s  = x_tlast_r;
        x_step_s   = x_step_r;
        f_s        = f_r;
        t_s        = t_r;
        issued_s   = issued_r;

        is_feat_s  = (f_r != LAST_F);
        // The output slot is free when empty or being emptied this cycle.
        load_s     = (state_r == ST_RUN) && !issued_r && (!x_valid_r || x_ready);

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s    = ST_RUN;
                    busy_s     = 1'b1;
                    mem_addr_s = ZERO;
                    f_s        = ZERO;
                    t_s        = ZERO;
                    issued_s   = 1'b0;
                end else begin
                    state_s    = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (load_s) begin
                    x_valid_s = 1'b1;
                    x_step_s  = t_r;
                    x_last_s  = !is_feat_s;
                    x_tlast_s = !is_feat_s && (t_r == LAST_T);
                    if (is_feat_s) begin
                        // The address is a running count, so the feature layout
                        // t*(NUM-1)+f follows without a multiplier.
                        x_out_s    = mem_data;
                        mem_addr_s = mem_addr_r + ONE;
                        f_s        = f_r + ONE;
                    end else begin
                        x_out_s  = BIAS;
                        f_s      = ZERO;
                        t_s      = t_r + ONE;
                        issued_s = (t_r == LAST_T);
                    end
                end else if (x_valid_r && x_ready) begin
                    x_valid_s = 1'b0;
                    x_last_s  = 1'b0;
                    x_tlast_s = 1'b0;
                    if (issued_r && x_tlast_r) begin
                        state_s = ST_DONE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    // Stalled or waiting: hold the offered element.
                    state_s = ST_RUN;
                end
            end

            ST_DONE: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end

            default: begin
                state_s   = ST_IDLE;
                busy_s    = 1'b0;
                x_valid_s = 1'b0;
                x_last_s  = 1'b0;
                x_tlast_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            mem_addr_r <= ZERO;
            x_out_r    <= ZERO;
            x_valid_r  <= 1'b0;
            x_last_r   <= 1'b0;
            x_tlast_r  <= 1'b0;
            x_step_r   <= ZERO;
            f_r        <= ZERO;
            t_r        <= ZERO;
            issued_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            mem_addr_r <= mem_addr_s;
            x_out_r    <= x_out_s;
            x_valid_r  <= x_valid_s;
            x_last_r   <= x_last_s;
            x_tlast_r  <= x_tlast_s;
            x_step_r   <= x_step_s;
            f_r        <= f_s;
            t_r        <= t_s;
            issued_r   <= issued_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign mem_addr = mem_addr_r;
    assign x_out    = x_out_r;
    assign x_valid  = x_valid_r;
    assign x_last   = x_last_r;
    assign x_tlast  = x_tlast_r;
    assign x_step   = x_step_r;

endmodule

// File: tb/tb_input_x_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for input_x_sequencer. A small instance (NUM=4, two timesteps) covers
// handshake, stall, restart and reset behaviour; a default-size instance checks
// the full 552-beat stream and its address coverage. Expected beats are pushed
// into queues when a sequence is started; monitors pop and compare on every
// handshake.
// -----------------------------------------------------------------------------
module tb_input_x_sequencer;

    localparam logic [31:0] BIAS = 32'h0100_0000;

    typedef struct packed {
        logic [31:0] d;
        logic        last;
        logic        tlast;
        logic [31:0] step;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic        x_ready;
    logic        x_ready2;

    logic        busy, done, x_valid, x_last, x_tlast;
    logic [31:0] mem_addr, mem_data, x_out, x_step;
    logic        busy2, done2, x_valid2, x_last2, x_tlast2;
    logic [31:0] mem_addr2, mem_data2, x_out2, x_step2;

    logic [31:0] rom [0:5];

    beat_t q1[$];
    beat_t q2[$];

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int cyc      = 0;
    int beats1   = 0;
    int beats2   = 0;
    int last2    = 0;
    int first_cyc = 0;
    int last_cyc  = 0;
    int ready_mode = 0;

    always #5 clk = ~clk;

    assign mem_data  = (mem_addr < 32'd6) ? rom[mem_addr[2:0]] : 32'hDEAD_BEEF;
    assign mem_data2 = {16'hA5C3, mem_addr2[15:0]};

    input_x_sequencer #(.WIDTH(32), .NUM(4), .NUM_ITERATIONS(2), .BIAS(BIAS)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_data(mem_data), .x_out(x_out), .x_valid(x_valid),
        .x_ready(x_ready), .x_last(x_last), .x_tlast(x_tlast), .x_step(x_step)
    );

    input_x_sequencer dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .mem_addr(mem_addr2), .mem_data(mem_data2), .x_out(x_out2), .x_valid(x_valid2),
        .x_ready(x_ready2), .x_last(x_last2), .x_tlast(x_tlast2), .x_step(x_step2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_seq1();
        for (int t = 0; t < 2; t++) begin
            for (int f = 0; f < 4; f++) begin
                beat_t b;
                b.d     = (f < 3) ? rom[t*3+f] : BIAS;
                b.last  = (f == 3);
                b.tlast = (f == 3) && (t == 1);
                b.step  = t;
                q1.push_back(b);
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done1(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check("done_seen", {63'd0, seen}, 64'd1);
    endtask

    // Ready driver: always-ready, or a 1,0,0,1 pattern followed by random stalls.
    initial begin
        int rk = 0;
        logic [3:0] pat = 4'b1001;
        x_ready  = 1'b1;
        x_ready2 = 1'b1;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (ready_mode == 0) begin
                x_ready = 1'b1;
                rk = 0;
            end else begin
                if (rk < 4) x_ready = pat[rk];
                else        x_ready = ($urandom_range(0, 1) == 1);
                rk++;
            end
        end
    end

    // Monitor for the small instance: scoreboard, stall stability, done timing.
    initial begin
        logic        tl_prev = 1'b0;
        logic        stall_prev = 1'b0;
        logic [31:0] stall_x = 32'd0;
        beat_t       e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                tl_prev    = 1'b0;
                stall_prev = 1'b0;
            end else begin
                if (tl_prev || done) check("done_pulse", {63'd0, done}, {63'd0, tl_prev});
                if (stall_prev) begin
                    check("stall_valid", {63'd0, x_valid}, 64'd1);
                    check("stall_hold", {32'd0, x_out}, {32'd0, stall_x});
                end
                tl_prev    = x_valid && x_ready && x_tlast;
                stall_prev = x_valid && !x_ready;
                stall_x    = x_out;
                if (x_valid && x_ready) begin
                    if (beats1 == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    beats1++;
                    if (q1.size() == 0) begin
                        check("unexpected_beat", {32'd0, x_out}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = q1.pop_front();
                        check("x_out",   {32'd0, x_out},   {32'd0, e.d});
                        check("x_last",  {63'd0, x_last},  {63'd0, e.last});
                        check("x_tlast", {63'd0, x_tlast}, {63'd0, e.tlast});
                        check("x_step",  {32'd0, x_step},  {32'd0, e.step});
                    end
                end
            end
        end
    end

    // Monitor for the default-size instance.
    initial begin
        logic  tl_prev = 1'b0;
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                tl_prev = 1'b0;
            end else begin
                if (tl_prev || done2) check("done2_pulse", {63'd0, done2}, {63'd0, tl_prev});
                tl_prev = x_valid2 && x_ready2 && x_tlast2;
                if (x_valid2 && x_ready2) begin
                    beats2++;
                    if (x_last2) last2++;
                    if (q2.size() == 0) begin
                        check("unexpected_beat2", {32'd0, x_out2}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = q2.pop_front();
                        if (x_out2 !== e.d || x_last2 !== e.last || x_tlast2 !== e.tlast || x_step2 !== e.step)
                            check("beat2", {x_out2, x_step2}, {e.d, e.step});
                        else
                            check("beat2", {x_out2, x_step2}, {e.d, e.step});
                    end
                end
            end
        end
    end

    // Global time limit so the run can never hang.
    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, passed %0d of %0d", pass_cnt, tot_cnt);
        $fatal(1);
    end

    // Directed stimulus.
    initial begin
        rom[0] = 32'h11; rom[1] = 32'h12; rom[2] = 32'h13;
        rom[3] = 32'h21; rom[4] = 32'h22; rom[5] = 32'h23;
        rst = 1'b1; start = 1'b0; start2 = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",     {63'd0, busy},    64'd0);
        check("rst_done",     {63'd0, done},    64'd0);
        check("rst_valid",    {63'd0, x_valid}, 64'd0);
        check("rst_flags",    {62'd0, x_last, x_tlast}, 64'd0);
        check("rst_xout",     {32'd0, x_out},   64'd0);
        check("rst_step",     {32'd0, x_step},  64'd0);
        check("rst_addr",     {32'd0, mem_addr}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Single sequence, ready always high: latency and throughput.
        ready_mode = 0; beats1 = 0;
        push_seq1();
        pulse_start();
        @(negedge clk);
        check("lat_busy",  {63'd0, busy},    64'd1);
        check("lat_valid0", {63'd0, x_valid}, 64'd0);
        @(negedge clk);
        check("lat_valid1", {63'd0, x_valid}, 64'd1);
        check("lat_first",  {32'd0, x_out},   64'h11);
        wait_done1(50);
        check("a_beats", beats1, 64'd8);
        check("a_span", last_cyc - first_cyc, 64'd7);
        check("a_qempty", q1.size(), 64'd0);
        check("a_busy_done", {63'd0, busy}, 64'd0);

        // Ready toggling with random stalls.
        repeat (2) @(posedge clk);
        #1 ready_mode = 1; beats1 = 0;
        push_seq1();
        pulse_start();
        wait_done1(300);
        check("b_beats", beats1, 64'd8);
        check("b_qempty", q1.size(), 64'd0);
        @(posedge clk); #1 ready_mode = 0;

        // Start mid-sequence and during the done cycle are ignored.
        repeat (2) @(posedge clk);
        #1 beats1 = 0;
        push_seq1();
        pulse_start();
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done1(50);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (6) @(negedge clk);
        check("c_idle_busy", {63'd0, busy}, 64'd0);
        check("c_idle_valid", {63'd0, x_valid}, 64'd0);
        check("c_beats", beats1, 64'd8);
        check("c_qempty", q1.size(), 64'd0);

        // Reset after beat 3, then restart from the first feature.
        @(posedge clk); #1 beats1 = 0;
        push_seq1();
        pulse_start();
        for (int i = 0; i < 40 && beats1 < 3; i++) @(posedge clk);
        check("d_beats3", beats1, 64'd3);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("d_valid", {63'd0, x_valid}, 64'd0);
        check("d_busy",  {63'd0, busy},    64'd0);
        check("d_addr",  {32'd0, mem_addr}, 64'd0);
        q1.delete();
        beats1 = 0;
        push_seq1();
        pulse_start();
        wait_done1(50);
        check("d_beats", beats1, 64'd8);

        // Back-to-back: start in the cycle right after done.
        @(posedge clk); #1 beats1 = 0;
        push_seq1();
        push_seq1();
        pulse_start();
        wait_done1(50);
        pulse_start();
        @(negedge clk);
        check("e_addr0", {32'd0, mem_addr}, 64'd0);
        check("e_busy",  {63'd0, busy},     64'd1);
        wait_done1(50);
        check("e_beats", beats1, 64'd16);
        check("e_qempty", q1.size(), 64'd0);

        // Default-size instance: 552 beats, contiguous addresses 0..543.
        for (int t = 0; t < 8; t++) begin
            for (int f = 0; f < 69; f++) begin
                beat_t b;
                logic [15:0] a;
                a       = 16'(t*68 + f);
                b.d     = (f < 68) ? {16'hA5C3, a} : BIAS;
                b.last  = (f == 68);
                b.tlast = (f == 68) && (t == 7);
                b.step  = t;
                q2.push_back(b);
            end
        end
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 1000 && !seen; i++) begin
                @(negedge clk);
                if (done2 === 1'b1) seen = 1'b1;
            end
            check("f_done_seen", {63'd0, seen}, 64'd1);
        end
        check("f_beats", beats2, 64'd552);
        check("f_lasts", last2, 64'd8);
        check("f_qempty", q2.size(), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
